// File: rtl/vliw_scoreboard_pkg.sv
// Shared definitions for the VLIW issue scoreboard and the decode stage that feeds it.
// Holds:
//   - slot field offsets inside the flattened per-slot buses,
//   - the source-readiness threshold,
//   - a slot_t packing helper used by decode to assemble one lane.
package vliw_scoreboard_pkg;

   localparam int SB_ADDR_MAX_W = 8;
   localparam int SB_LAT_MAX_W  = 4;

   typedef struct packed {
      logic [SB_ADDR_MAX_W-1:0] src_a;
      logic [SB_ADDR_MAX_W-1:0] src_b;
      logic [SB_ADDR_MAX_W-1:0] dst;
      logic                     wen;
      logic [SB_LAT_MAX_W-1:0]  lat;
   } slot_t;

   // LSB position of a slot's field in a flattened bus (slot 0 in the LSBs).
   function automatic int fld_lo(input int slot, input int w);
      return slot * w;
   endfunction

   // With bypass, a result one cycle from readable is already usable.
   function automatic int sb_th(input int fwd);
      return (fwd != 0) ? 1 : 0;
   endfunction

   function automatic slot_t make_slot(input logic [SB_ADDR_MAX_W-1:0] a,
                                       input logic [SB_ADDR_MAX_W-1:0] b,
                                       input logic [SB_ADDR_MAX_W-1:0] d,
                                       input logic                     w,
                                       input logic [SB_LAT_MAX_W-1:0]  l);
      slot_t s;
      s.src_a = a;
      s.src_b = b;
      s.dst   = d;
      s.wen   = w;
      s.lat   = l;
      return s;
   endfunction

endpackage

// File: rtl/vliw_scoreboard_if.sv
// Decode-to-scoreboard issue bus.
// master (decode): drives the bundle fields and flush, receives stall/issue_fire.
// slave (scoreboard): consumes the bundle, returns stall and per-slot issue_fire.
interface vliw_scoreboard_if #(
   parameter int NUM_SLOTS = 2,
   parameter int ADDR_W    = 3,
   parameter int LAT_W     = 2
);
   logic                        bundle_valid;
   logic [NUM_SLOTS-1:0]        slot_en;
   logic [NUM_SLOTS*ADDR_W-1:0] src_a;
   logic [NUM_SLOTS*ADDR_W-1:0] src_b;
   logic [NUM_SLOTS*ADDR_W-1:0] dst;
   logic [NUM_SLOTS-1:0]        wen;
   logic [NUM_SLOTS*LAT_W-1:0]  lat;
   logic                        flush;
   logic                        stall;
   logic [NUM_SLOTS-1:0]        issue_fire;

   modport master (output bundle_valid, slot_en, src_a, src_b, dst, wen, lat, flush,
                   input  stall, issue_fire);
   modport slave  (input  bundle_valid, slot_en, src_a, src_b, dst, wen, lat, flush,
                   output stall, issue_fire);
endinterface

// File: rtl/vliw_scoreboard_reg_counter.sv
// sb_reg_counter: per-register countdown of cycles until a pending result is readable.
// Ports: clk, reset (async active-low), flush (clear), load/load_val (start a new
// countdown), cnt (current value), busy (cnt != 0).
module sb_reg_counter
   import vliw_scoreboard_pkg::*;
#(
   parameter int LAT_W = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             load,
   input  logic [LAT_W-1:0] load_val,
   output logic [LAT_W-1:0] cnt,
   output logic             busy
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (flush) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - LAT_W'(1);
      end
   end

   assign busy = (cnt != '0);

endmodule

// File: rtl/vliw_scoreboard.sv
// vliw_scoreboard: issue-side RAW/WAW hazard scoreboard for an NUM_SLOTS-wide VLIW bundle.
// Ports: clk, reset (async active-low), bus (slave side of the issue bus: bundle in,
// stall/issue_fire out), busy_vec (per-register pending result), illegal_bundle (sticky
// same-destination conflict), stall_cycles (saturating stall counter).
module vliw_scoreboard
   import vliw_scoreboard_pkg::*;
#(
   parameter int NUM_SLOTS = 2,
   parameter int NUM_REGS  = 8,
   parameter int ADDR_W    = 3,
   parameter int LAT_W     = 2,
   parameter int FWD       = 1,
   parameter int CNT_W     = 16
) (
   input  logic                clk,
   input  logic                reset,
   vliw_scoreboard_if.slave    bus,
   output logic [NUM_REGS-1:0] busy_vec,
   output logic                illegal_bundle,
   output logic [CNT_W-1:0]    stall_cycles
);

   localparam int              DEPTH = 2 ** ADDR_W;
   localparam logic [LAT_W-1:0] TH_V = LAT_W'(sb_th(FWD));

   // Untracked addresses (>= NUM_REGS) read as a constant 0: always ready, never busy.
   logic [LAT_W-1:0]    cnt      [DEPTH];
   logic [NUM_REGS-1:0] load;
   logic [LAT_W-1:0]    load_val [NUM_REGS];
   logic                hazard;
   logic                conflict;
   logic [ADDR_W-1:0]   a_s, b_s, d_s, d_i, d_j;
   logic [LAT_W-1:0]    l_s;

   for (genvar r = 0; r < DEPTH; r++) begin : g_reg
      if (r < NUM_REGS) begin : g_trk
         sb_reg_counter #(.LAT_W(LAT_W)) u_cnt (
            .clk      (clk),
            .reset    (reset),
            .flush    (bus.flush),
            .load     (load[r]),
            .load_val (load_val[r]),
            .cnt      (cnt[r]),
            .busy     (busy_vec[r])
         );
      end else begin : g_idle
         assign cnt[r] = '0;
      end
   end

   // All slots compare against pre-bundle counter state; no intra-bundle bypass.
   always_comb begin
      hazard = 1'b0;
      a_s    = '0;
      b_s    = '0;
      d_s    = '0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
         a_s = bus.src_a[fld_lo(s, ADDR_W) +: ADDR_W];
         b_s = bus.src_b[fld_lo(s, ADDR_W) +: ADDR_W];
         d_s = bus.dst[fld_lo(s, ADDR_W) +: ADDR_W];
         if (bus.slot_en[s]) begin
            if ((cnt[a_s] > TH_V) || (cnt[b_s] > TH_V)) hazard = 1'b1;
            if (bus.wen[s] && (cnt[d_s] != '0))          hazard = 1'b1;
         end
      end
   end

   assign bus.stall      = bus.bundle_valid & hazard;
   assign bus.issue_fire = bus.slot_en & {NUM_SLOTS{bus.bundle_valid & ~bus.stall & ~bus.flush}};

   // Ascending slot order lets the highest-numbered writer win a duplicate dst.
   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
         load[r]     = 1'b0;
         load_val[r] = '0;
      end
      l_s = '0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
         l_s = bus.lat[fld_lo(s, LAT_W) +: LAT_W];
         if (bus.issue_fire[s] && bus.wen[s] && (l_s != '0)) begin
            for (int r = 0; r < NUM_REGS; r++) begin
               if (int'(bus.dst[fld_lo(s, ADDR_W) +: ADDR_W]) == r) begin
                  load[r]     = 1'b1;
                  load_val[r] = l_s;
               end
            end
         end
      end
   end

   always_comb begin
      conflict = 1'b0;
      d_i      = '0;
      d_j      = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         for (int j = i + 1; j < NUM_SLOTS; j++) begin
            d_i = bus.dst[fld_lo(i, ADDR_W) +: ADDR_W];
            d_j = bus.dst[fld_lo(j, ADDR_W) +: ADDR_W];
            if (bus.issue_fire[i] && bus.issue_fire[j] && bus.wen[i] && bus.wen[j] && (d_i == d_j))
               conflict = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         illegal_bundle <= 1'b0;
         stall_cycles   <= '0;
      end else begin
         if (conflict) illegal_bundle <= 1'b1;
         if (bus.stall && !bus.flush && (stall_cycles != '1))
            stall_cycles <= stall_cycles + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_vliw_scoreboard.sv
// Directed bench: one FWD=1 scoreboard and one FWD=0 scoreboard (2-bit stall counter)
// fed the same bundle stream; expected values are hand-derived per vector.
module tb_vliw_scoreboard;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic       bv, fl;
   logic [1:0] en, w;
   logic [5:0] sa, sb, d;
   logic [3:0] l;

   logic [7:0]  busy1, busy0;
   logic        ill1, ill0;
   logic [15:0] sc1;
   logic [1:0]  sc0;

   int n_chk = 0;
   int n_bad = 0;

   vliw_scoreboard_if #(.NUM_SLOTS(2), .ADDR_W(3), .LAT_W(2)) if1 ();
   vliw_scoreboard_if #(.NUM_SLOTS(2), .ADDR_W(3), .LAT_W(2)) if0 ();

   assign if1.bundle_valid = bv;  assign if0.bundle_valid = bv;
   assign if1.slot_en      = en;  assign if0.slot_en      = en;
   assign if1.src_a        = sa;  assign if0.src_a        = sa;
   assign if1.src_b        = sb;  assign if0.src_b        = sb;
   assign if1.dst          = d;   assign if0.dst          = d;
   assign if1.wen          = w;   assign if0.wen          = w;
   assign if1.lat          = l;   assign if0.lat          = l;
   assign if1.flush        = fl;  assign if0.flush        = fl;

   vliw_scoreboard #(.NUM_SLOTS(2), .NUM_REGS(8), .ADDR_W(3), .LAT_W(2), .FWD(1), .CNT_W(16)) dut_f1 (
      .clk(clk), .reset(reset), .bus(if1.slave),
      .busy_vec(busy1), .illegal_bundle(ill1), .stall_cycles(sc1));

   vliw_scoreboard #(.NUM_SLOTS(2), .NUM_REGS(8), .ADDR_W(3), .LAT_W(2), .FWD(0), .CNT_W(2)) dut_f0 (
      .clk(clk), .reset(reset), .bus(if0.slave),
      .busy_vec(busy0), .illegal_bundle(ill0), .stall_cycles(sc0));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Present one cycle of inputs at the falling edge, settle, then return for checks.
   task automatic step(input logic v, input logic [1:0] e,
                       input logic [2:0] a1, input logic [2:0] a0,
                       input logic [2:0] d1, input logic [2:0] d0,
                       input logic [1:0] wv, input logic [1:0] l1, input logic [1:0] l0,
                       input logic f);
      @(negedge clk);
      bv = v;  en = e;  sa = {a1, a0};  sb = 6'd0;
      d  = {d1, d0};  w = wv;  l = {l1, l0};  fl = f;
      #1;
   endtask

   task automatic idle();
      step(1'b0, 2'b00, 3'd0, 3'd0, 3'd0, 3'd0, 2'b00, 2'd0, 2'd0, 1'b0);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      bv = 1'b0; en = '0; sa = '0; sb = '0; d = '0; w = '0; l = '0; fl = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      do_reset();

      // Reset state
      idle();
      chk("rst_busy",  busy1, 8'h00);
      chk("rst_stall", if1.stall, 1'b0);
      chk("rst_sc",    sc1, 16'd0);
      chk("rst_ill",   ill1, 1'b0);

      // RAW with lat=3 on r3: FWD=1 fires in cycle 3, FWD=0 in cycle 4
      step(1'b1, 2'b01, 3'd0, 3'd0, 3'd0, 3'd3, 2'b01, 2'd0, 2'd3, 1'b0);
      chk("raw_c0_fire1", if1.issue_fire, 2'b01);
      chk("raw_c0_fire0", if0.issue_fire, 2'b01);
      step(1'b1, 2'b10, 3'd3, 3'd0, 3'd0, 3'd0, 2'b00, 2'd0, 2'd0, 1'b0);
      chk("raw_c1_stall1", if1.stall, 1'b1);
      chk("raw_c1_stall0", if0.stall, 1'b1);
      chk("raw_c1_busy",   busy1, 8'h08);
      step(1'b1, 2'b10, 3'd3, 3'd0, 3'd0, 3'd0, 2'b00, 2'd0, 2'd0, 1'b0);
      chk("raw_c2_stall1", if1.stall, 1'b1);
      chk("raw_c2_stall0", if0.stall, 1'b1);
      step(1'b1, 2'b10, 3'd3, 3'd0, 3'd0, 3'd0, 2'b00, 2'd0, 2'd0, 1'b0);
      chk("raw_c3_fire1",  if1.issue_fire, 2'b10);
      chk("raw_c3_stall0", if0.stall, 1'b1);
      chk("raw_c3_fire0",  if0.issue_fire, 2'b00);
      chk("raw_c3_busy",   busy1, 8'h08);
      step(1'b1, 2'b10, 3'd3, 3'd0, 3'd0, 3'd0, 2'b00, 2'd0, 2'd0, 1'b0);
      chk("raw_c4_fire0",  if0.issue_fire, 2'b10);
      chk("raw_c4_busy0",  busy0, 8'h00);
      idle();
      chk("raw_sc1", sc1, 16'd2);
      chk("raw_sc0", sc0, 2'd3);

      // WAW on r5 (no reset: stall counts accumulate, FWD=0 counter saturates at 3)
      step(1'b1, 2'b01, 3'd0, 3'd0, 3'd0, 3'd5, 2'b01, 2'd0, 2'd2, 1'b0);
      chk("waw_c0_fire", if1.issue_fire, 2'b01);
      step(1'b1, 2'b01, 3'd0, 3'd0, 3'd0, 3'd5, 2'b01, 2'd0, 2'd1, 1'b0);
      chk("waw_c1_stall", if1.stall, 1'b1);
      step(1'b1, 2'b01, 3'd0, 3'd0, 3'd0, 3'd5, 2'b01, 2'd0, 2'd1, 1'b0);
      chk("waw_c2_stall", if1.stall, 1'b1);
      step(1'b1, 2'b01, 3'd0, 3'd0, 3'd0, 3'd5, 2'b01, 2'd0, 2'd1, 1'b0);
      chk("waw_c3_fire", if1.issue_fire, 2'b01);
      chk("waw_c3_busy", busy1, 8'h00);
      idle();
      chk("waw_c4_busy", busy1, 8'h20);
      idle();
      chk("waw_c5_busy", busy1, 8'h00);
      chk("waw_sc1",     sc1, 16'd4);
      chk("sat_sc0",     sc0, 2'd3);

      // Flush kills r2's pending result
      do_reset();
      step(1'b1, 2'b01, 3'd0, 3'd0, 3'd0, 3'd2, 2'b01, 2'd0, 2'd3, 1'b0);
      step(1'b1, 2'b10, 3'd2, 3'd0, 3'd0, 3'd0, 2'b00, 2'd0, 2'd0, 1'b1);
      chk("fl_fire",  if1.issue_fire, 2'b00);
      chk("fl_stall", if1.stall, 1'b1);
      chk("fl_busy",  busy1, 8'h04);
      step(1'b1, 2'b10, 3'd2, 3'd0, 3'd0, 3'd0, 2'b00, 2'd0, 2'd0, 1'b0);
      chk("fl_busy_after", busy1, 8'h00);
      chk("fl_fire1", if1.issue_fire, 2'b10);
      chk("fl_fire0", if0.issue_fire, 2'b10);
      idle();
      chk("fl_sc", sc1, 16'd0);

      // Illegal bundle: both slots write r4, slot 1 (lat 3) wins
      do_reset();
      step(1'b1, 2'b11, 3'd0, 3'd0, 3'd4, 3'd4, 2'b11, 2'd3, 2'd1, 1'b0);
      chk("ill_fire",  if1.issue_fire, 2'b11);
      chk("ill_c0",    ill1, 1'b0);
      idle();
      chk("ill_c1",    ill1, 1'b1);
      chk("ill_busy1", busy1, 8'h10);
      idle();
      idle();
      chk("ill_busy3", busy1, 8'h10);
      chk("ill_held",  ill1, 1'b1);

      // Asynchronous reset mid-operation
      #2;
      reset = 1'b0;
      #1;
      chk("arst_busy", busy1, 8'h00);
      chk("arst_ill",  ill1, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      idle();
      chk("arst_after_ill", ill1, 1'b0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
